// File: rtl/display_7seg_multiplexado_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-low gfedcba
// segment patterns, digit slot indices and the buffered display value record.
package display_7seg_multiplexado_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] SLOT_UNI = 2'd0;
    localparam logic [1:0] SLOT_DEC = 2'd1;
    localparam logic [1:0] SLOT_CEN = 2'd2;
    localparam logic [1:0] SLOT_SGN = 2'd3;

    typedef struct packed {
        logic [3:0] cen;
        logic [3:0] dec;
        logic [3:0] uni;
        logic       neg;
    } bcd_value_t;

endpackage

// File: rtl/display_7seg_multiplexado_bcd_a_7seg.sv
// Combinational BCD nibble to active-low 7-segment pattern; blank wins over
// minus, minus wins over the digit, nibbles above 9 render as 'E'.
module bcd_a_7seg
    import display_7seg_multiplexado_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    // Pattern selection with blank/minus overrides
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (minus) begin
            seg = SEG_MINUS;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/display_7seg_multiplexado.sv
// 4-digit common-anode display driver: refresh/slot counters, double-buffered
// BCD value (pending -> display at frame boundary) and registered anode/segment outputs.
module display_7seg_multiplexado
    import display_7seg_multiplexado_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bcd_valid,
    input  logic [3:0] unidades,
    input  logic [3:0] decenas,
    input  logic [3:0] centenas,
    input  logic       negativo,
    input  logic       blank_zeros,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       slot_r;
    logic             tick_s;
    logic             boundary_s;
    bcd_value_t       in_s;
    bcd_value_t       pend_r;
    bcd_value_t       disp_r;
    logic             pend_flag_r;
    logic [3:0]       mux_digit_s;
    logic             mux_blank_s;
    logic             mux_minus_s;
    logic [6:0]       seg_s;
    logic [3:0]       an_s;
    logic [6:0]       seg_r;
    logic [3:0]       an_r;
    logic             frame_done_r;

    assign in_s       = {centenas, decenas, unidades, negativo};
    assign tick_s     = (cnt_r == CNT_LAST);
    assign boundary_s = tick_s && (slot_r == SLOT_SGN);

    // Slot mux: pick the digit for the active slot and decide leading-zero blanking
    always_comb begin
        mux_digit_s = 4'd0;
        mux_blank_s = 1'b0;
        mux_minus_s = 1'b0;
        an_s        = 4'b1111;
        case (slot_r)
            SLOT_UNI: begin
                mux_digit_s = disp_r.uni;
                an_s        = 4'b1110;
            end
            SLOT_DEC: begin
                mux_digit_s = disp_r.dec;
                mux_blank_s = blank_zeros && (disp_r.cen == 4'd0) && (disp_r.dec == 4'd0);
                an_s        = 4'b1101;
            end
            SLOT_CEN: begin
                mux_digit_s = disp_r.cen;
                mux_blank_s = blank_zeros && (disp_r.cen == 4'd0);
                an_s        = 4'b1011;
            end
            SLOT_SGN: begin
                mux_blank_s = ~disp_r.neg;
                mux_minus_s = 1'b1;
                an_s        = 4'b0111;
            end
            default: begin
                mux_digit_s = 4'd0;
                mux_blank_s = 1'b1;
                mux_minus_s = 1'b0;
                an_s        = 4'b1111;
            end
        endcase
    end

    bcd_a_7seg u_bcd_a_7seg (
        .digit (mux_digit_s),
        .blank (mux_blank_s),
        .minus (mux_minus_s),
        .seg   (seg_s)
    );

    // Refresh divider and digit slot sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            slot_r <= SLOT_UNI;
        end else if (tick_s) begin
            cnt_r  <= '0;
            slot_r <= slot_r + 2'd1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            slot_r <= slot_r;
        end
    end

    // Double buffer: a strobe on the boundary bypasses pending so the newest value wins
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= '0;
            disp_r      <= '0;
            pend_flag_r <= 1'b0;
        end else if (bcd_valid && boundary_s) begin
            pend_r      <= pend_r;
            disp_r      <= in_s;
            pend_flag_r <= 1'b0;
        end else if (bcd_valid) begin
            pend_r      <= in_s;
            disp_r      <= disp_r;
            pend_flag_r <= 1'b1;
        end else if (boundary_s && pend_flag_r) begin
            pend_r      <= pend_r;
            disp_r      <= pend_r;
            pend_flag_r <= 1'b0;
        end else begin
            pend_r      <= pend_r;
            disp_r      <= disp_r;
            pend_flag_r <= pend_flag_r;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r         <= 4'b1111;
            seg_r        <= SEG_BLANK;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_s;
            seg_r        <= seg_s;
            frame_done_r <= boundary_s;
        end
    end

    assign seg        = seg_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;
    assign dp         = 1'b1;

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
// Table-driven bench for display_7seg_multiplexado with REFRESH_DIV=4 (16-cycle frames).
module tb_display_7seg_multiplexado;

    typedef struct packed {
        logic [3:0]      cen;
        logic [3:0]      dec;
        logic [3:0]      uni;
        logic            neg;
        logic            bz;
        logic [3:0][6:0] exp;   // index 0 = unidades slot ... 3 = sign slot
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       bcd_valid;
    logic [3:0] unidades;
    logic [3:0] decenas;
    logic [3:0] centenas;
    logic       negativo;
    logic       blank_zeros;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [7];
    vec_t none;

    display_7seg_multiplexado #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_valid   (bcd_valid),
        .unidades    (unidades),
        .decenas     (decenas),
        .centenas    (centenas),
        .negativo    (negativo),
        .blank_zeros (blank_zeros),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                                input logic n, input logic b, input logic [6:0] e_uni,
                                input logic [6:0] e_dec, input logic [6:0] e_cen, input logic [6:0] e_sgn);
        vec_t v;
        v.cen = c;
        v.dec = d;
        v.uni = u;
        v.neg = n;
        v.bz  = b;
        v.exp = {e_sgn, e_cen, e_dec, e_uni};
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, expv);
        end
    endtask

    task automatic set_in(input vec_t v);
        centenas = v.cen;
        decenas  = v.dec;
        unidades = v.uni;
        negativo = v.neg;
    endtask

    task automatic strobe(input vec_t v);
        set_in(v);
        blank_zeros = v.bz;
        bcd_valid   = 1'b1;
        @(negedge clk);
        bcd_valid   = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        for (int k = 0; k < 40; k++) begin
            if (frame_done === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done timeout got %b expected 1", name, frame_done);
        end
    endtask

    // Called at the negedge where frame_done is seen; checks the following frame.
    task automatic check_frame(input logic [3:0][6:0] expv, input string name,
                               input int at1, input vec_t v1, input int at2, input vec_t v2);
        logic [3:0] ea;
        int         s;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == at1) begin
                set_in(v1);
                bcd_valid = 1'b1;
            end else if (i == at2) begin
                set_in(v2);
                bcd_valid = 1'b1;
            end else begin
                bcd_valid = 1'b0;
            end
            s  = i / 4;
            ea = ~(4'b0001 << s);
            chk($sformatf("%s c%0d an", name, i), {4'b0000, an}, {4'b0000, ea});
            chk($sformatf("%s c%0d seg", name, i), {1'b0, seg}, {1'b0, expv[s]});
            chk($sformatf("%s c%0d frame_done", name, i), {7'b0000000, frame_done},
                {7'b0000000, (i == 15) ? 1'b1 : 1'b0});
            if (i == 0) chk($sformatf("%s dp", name), {7'b0000000, dp}, 8'h01);
        end
        bcd_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111);
        vecs[1] = mk(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 7'b1111000, 7'b1111111, 7'b1111111, 7'b0111111);
        vecs[2] = mk(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 7'b1111000, 7'b1000000, 7'b1000000, 7'b0111111);
        vecs[3] = mk(4'd0, 4'hC, 4'd5, 1'b0, 1'b1, 7'b0010010, 7'b0000110, 7'b1111111, 7'b1111111);
        vecs[4] = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
        vecs[5] = mk(4'd9, 4'd0, 4'd8, 1'b0, 1'b1, 7'b0000000, 7'b1000000, 7'b0010000, 7'b1111111);
        vecs[6] = mk(4'hF, 4'd6, 4'd4, 1'b1, 1'b1, 7'b0011001, 7'b0000010, 7'b0000110, 7'b0111111);
        none    = '0;

        rst         = 1'b1;
        bcd_valid   = 1'b0;
        unidades    = 4'd0;
        decenas     = 4'd0;
        centenas    = 4'd0;
        negativo    = 1'b0;
        blank_zeros = 1'b1;

        // Reset held for five cycles
        repeat (5) begin
            @(negedge clk);
            chk("rst an", {4'b0000, an}, 8'h0F);
            chk("rst seg", {1'b0, seg}, 8'h7F);
            chk("rst dp", {7'b0000000, dp}, 8'h01);
            chk("rst frame_done", {7'b0000000, frame_done}, 8'h00);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("release an", {4'b0000, an}, 8'h0E);
        chk("release seg", {1'b0, seg}, {1'b0, 7'b1000000});
        wait_fd("reset_frame");
        check_frame(vecs[4].exp, "reset_frame", -1, none, -1, none);

        // Table of values, each shown from the frame after its strobe
        for (int v = 0; v < 7; v++) begin
            strobe(vecs[v]);
            wait_fd($sformatf("vec%0d", v));
            check_frame(vecs[v].exp, $sformatf("vec%0d", v), -1, none, -1, none);
        end

        // Mid-frame strobe: current frame keeps the old value
        check_frame(vecs[6].exp, "mid_old", 3, vecs[0], -1, none);
        check_frame(vecs[0].exp, "mid_new", -1, none, -1, none);

        // Two strobes in one frame: only the last is shown
        check_frame(vecs[0].exp, "twice_old", 2, vecs[1], 9, vecs[3]);
        check_frame(vecs[3].exp, "twice_last", -1, none, -1, none);

        // Strobe on the boundary edge overrides the earlier pending value
        check_frame(vecs[3].exp, "coinc_old", 3, vecs[4], 14, vecs[5]);
        check_frame(vecs[5].exp, "coinc_new", -1, none, -1, none);
        check_frame(vecs[5].exp, "coinc_hold", -1, none, -1, none);

        // Reset mid-frame with a pending value: the pending value is lost
        repeat (3) @(negedge clk);
        strobe(vecs[0]);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst an", {4'b0000, an}, 8'h0F);
            chk("midrst seg", {1'b0, seg}, 8'h7F);
            chk("midrst frame_done", {7'b0000000, frame_done}, 8'h00);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midrst release an", {4'b0000, an}, 8'h0E);
        chk("midrst release seg", {1'b0, seg}, {1'b0, 7'b1000000});
        wait_fd("midrst_frame");
        check_frame(vecs[4].exp, "midrst_frame", -1, none, -1, none);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
